fifo_burst_reader: RTL and testbench

Read-side controller for the general-purpose show-ahead FIFO. It pops entries in fixed-length bursts and buffers them in a 2-entry skid buffer. It presents them downstream as a valid/ready stream with a last-of-burst marker. It sits between a FIFO and a downstream consumer such as a reduction or accumulation stage, and owns the FIFO's `consume` input.

---
 rtl/fifo_burst_reader_if.sv | 28 ++
 rtl/fifo_burst_reader.sv | 117 +++++++++++
 tb/tb_fifo_burst_reader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side and downstream stream signals of the burst reader.
interface fifo_burst_reader_if #(
    parameter int unsigned FIFO_depth = 8,
    parameter int unsigned FIFO_width = 64
);
    logic [FIFO_width-1:0] fifo_out;
    logic                  fifo_empty;
    logic [FIFO_depth-1:0] fifo_util;
    logic                  fifo_consume;
    logic                  drain_req;
    logic [FIFO_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic                  busy;
    logic [31:0]           word_count;
    logic [15:0]           burst_count;

    modport master (
        input  fifo_out, fifo_empty, fifo_util, drain_req, out_ready,
        output fifo_consume, out_data, out_valid, out_last, busy, word_count, burst_count
    );

    modport slave (
        output fifo_out, fifo_empty, fifo_util, drain_req, out_ready,
        input  fifo_consume, out_data, out_valid, out_last, busy, word_count, burst_count
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a show-ahead FIFO in fixed-length bursts into a 2-entry skid buffer and
// presents the words downstream as a valid/ready stream with a last-of-burst tag.
module fifo_burst_reader #(
    parameter int unsigned FIFO_depth = 8,
    parameter int unsigned FIFO_width = 64,
    parameter int unsigned BURST_LEN  = 4
) (
    input logic                 clk,
    input logic                 rst,
    fifo_burst_reader_if.master bus
);
    localparam int unsigned REM_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_nx;
    logic [REM_W-1:0]      remaining, remaining_nx, load_len;
    logic [31:0]           util;
    logic                  start, push, pop;

    logic [FIFO_width-1:0] skid_data [2];
    logic                  skid_last [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            occ;
    logic [31:0]           word_count;
    logic [15:0]           burst_count;

    assign util = 32'(bus.fifo_util);

    // Burst trigger, load length and downstream transfer
    always_comb begin
        start    = (util >= BURST_LEN) || (bus.drain_req && (util != 32'd0));
        load_len = (util >= BURST_LEN) ? REM_W'(BURST_LEN) : REM_W'(util);
        pop      = (occ != 2'd0) && bus.out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
        end
    end

    // Next state; a pop may reuse the skid slot freed by a same-cycle transfer
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx     = BURST;
                    remaining_nx = load_len;
                end
            end
            BURST: begin
                push = (remaining != '0) && !bus.fifo_empty && ((occ != 2'd2) || pop);
                if (push) begin
                    remaining_nx = remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                skid_data[i] <= '0;
                skid_last[i] <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                skid_data[wr_ptr] <= bus.fifo_out;
                skid_last[wr_ptr] <= (remaining == REM_W'(1));
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count  <= 32'd0;
            burst_count <= 16'd0;
        end else if (pop) begin
            word_count <= word_count + 32'd1;
            if (skid_last[rd_ptr]) begin
                burst_count <= burst_count + 16'd1;
            end
        end
    end

    assign bus.fifo_consume = push;
    assign bus.out_valid    = (occ != 2'd0);
    assign bus.out_data     = skid_data[rd_ptr];
    assign bus.out_last     = skid_last[rd_ptr];
    assign bus.busy         = (state == BURST) || (occ != 2'd0);
    assign bus.word_count   = word_count;
    assign bus.burst_count  = burst_count;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: instance 0 uses BURST_LEN=4, instance 1 BURST_LEN=7,
// each fed by a small show-ahead FIFO model holding DEPTH-1 words.
module tb_fifo_burst_reader;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned QN    = 4096;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             chk_last;
    } exp_t;

    typedef struct {
        logic             rdy;
        logic             cons;
        logic             vld;
        logic [WIDTH-1:0] data;
        logic             last;
        logic             busy;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             wr_en   [2];
    logic [WIDTH-1:0] wr_data [2];
    logic             rdy     [2];
    logic             drn     [2];
    logic             vld     [2];
    logic             lst     [2];
    logic             cons    [2];
    logic             busy_s  [2];
    logic [WIDTH-1:0] dat     [2];
    logic [31:0]      wcnt    [2];
    logic [15:0]      bcnt    [2];
    logic [DEPTH-1:0] fcnt    [2];

    exp_t             expv [2][QN];
    int               ewr [2];
    int               erd [2];
    bit               mon_en [2];
    int               pops [2];
    int               run [2];
    int               maxrun [2];
    int               lasts [2];
    int               runw [2];
    bit               hold [2];
    logic [WIDTH-1:0] hd [2];
    logic             hl [2];
    logic             last_seen [2];
    int               total;
    int               bad;
    bit               pdone;
    vec_t             tbl [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned BL = (g == 0) ? 4 : 7;

        fifo_burst_reader_if #(.FIFO_depth(DEPTH), .FIFO_width(WIDTH)) bus ();

        logic [WIDTH-1:0] mem [DEPTH];
        logic [2:0]       rp, wp;
        logic [DEPTH-1:0] cnt;
        logic             do_push;

        assign do_push = wr_en[g] && (cnt != DEPTH'(DEPTH - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rp  <= 3'd0;
                wp  <= 3'd0;
                cnt <= '0;
            end else begin
                if (do_push) begin
                    mem[wp] <= wr_data[g];
                    wp      <= wp + 3'd1;
                end
                if (bus.fifo_consume) rp <= rp + 3'd1;
                cnt <= cnt + DEPTH'(do_push) - DEPTH'(bus.fifo_consume);
            end
        end

        assign bus.fifo_out   = mem[rp];
        assign bus.fifo_empty = (cnt == '0);
        assign bus.fifo_util  = cnt;
        assign bus.drain_req  = drn[g];
        assign bus.out_ready  = rdy[g];
        assign vld[g]    = bus.out_valid;
        assign lst[g]    = bus.out_last;
        assign dat[g]    = bus.out_data;
        assign cons[g]   = bus.fifo_consume;
        assign busy_s[g] = bus.busy;
        assign wcnt[g]   = bus.word_count;
        assign bcnt[g]   = bus.burst_count;
        assign fcnt[g]   = cnt;

        fifo_burst_reader #(
            .FIFO_depth(DEPTH), .FIFO_width(WIDTH), .BURST_LEN(BL)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.master)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [WIDTH-1:0] d);
        int n = 0;
        while (fcnt[i] == DEPTH'(DEPTH - 1) && n < 200) begin
            cyc();
            n++;
        end
        chk("push_timeout", 64'(n >= 200), 64'd0);
        wr_en[i]   = 1'b1;
        wr_data[i] = d;
        cyc();
        wr_en[i]   = 1'b0;
    endtask

    task automatic enq(input int i, input logic [WIDTH-1:0] d, input logic l, input logic c);
        expv[i][ewr[i] % QN] = '{d, l, c};
        ewr[i]++;
    endtask

    task automatic wait_drain(input int i, input int budget);
        int n = 0;
        while ((erd[i] != ewr[i] || busy_s[i]) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 64'(n >= budget), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    // Negedge scoreboard: expected words, hold stability, pop and burst-length tracking
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    erd[i]  = ewr[i];
                    hold[i] = 1'b0;
                    run[i]  = 0;
                    runw[i] = 0;
                end else begin
                    if (cons[i]) begin
                        pops[i]++;
                        run[i]++;
                        if (run[i] > maxrun[i]) maxrun[i] = run[i];
                    end else begin
                        run[i] = 0;
                    end
                    if (hold[i]) begin
                        chk("stall_valid", 64'(vld[i]), 64'd1);
                        chk("stall_data", dat[i], hd[i]);
                        chk("stall_last", 64'(lst[i]), 64'(hl[i]));
                    end
                    hold[i] = vld[i] && !rdy[i];
                    hd[i]   = dat[i];
                    hl[i]   = lst[i];
                    if (vld[i] && rdy[i]) begin
                        if (lst[i]) lasts[i]++;
                        last_seen[i] = lst[i];
                        if (mon_en[i]) begin
                            if (erd[i] == ewr[i]) begin
                                chk("unexpected_word", dat[i], 64'hdead);
                            end else begin
                                e = expv[i][erd[i] % QN];
                                chk("out_data", dat[i], e.data);
                                if (e.chk_last) chk("out_last", 64'(lst[i]), 64'(e.last));
                                erd[i]++;
                            end
                            runw[i]++;
                            if (lst[i]) begin
                                chk("burst_len", 64'(runw[i] <= ((i == 0) ? 4 : 7)), 64'd1);
                                runw[i] = 0;
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int p0;
        int l0;
        // rdy, cons, vld, data, last, busy per cycle after the 4th write of 0x10..0x13
        tbl[0] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 64'h10, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 64'h11, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 64'h12, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 64'h13, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0};

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
            rdy[i]     = 1'b0;
            drn[i]     = 1'b0;
            mon_en[i]  = 1'b0;
        end
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(vld[0]), 64'd0);
        chk("rst_consume", 64'(cons[0]), 64'd0);
        chk("rst_busy", 64'(busy_s[0]), 64'd0);
        chk("rst_last", 64'(lst[0]), 64'd0);
        chk("rst_data", dat[0], 64'd0);
        chk("rst_wcnt", 64'(wcnt[0]), 64'd0);
        chk("rst_bcnt", 64'(bcnt[0]), 64'd0);
        rst = 1'b0;
        cyc();

        // Full burst streaming, cycle-exact
        rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) push(0, 64'h10 + 64'(k));
        for (int k = 0; k < 8; k++) begin
            rdy[0] = tbl[k].rdy;
            @(negedge clk);
            chk("tbl_consume", 64'(cons[0]), 64'(tbl[k].cons));
            chk("tbl_valid", 64'(vld[0]), 64'(tbl[k].vld));
            chk("tbl_busy", 64'(busy_s[0]), 64'(tbl[k].busy));
            if (tbl[k].vld) begin
                chk("tbl_data", dat[0], tbl[k].data);
                chk("tbl_last", 64'(lst[0]), 64'(tbl[k].last));
            end
            cyc();
        end
        chk("full_wcnt", 64'(wcnt[0]), 64'd4);
        chk("full_bcnt", 64'(bcnt[0]), 64'd1);

        // Under threshold, then drain
        do_reset();
        mon_en[0] = 1'b1;
        for (int k = 0; k < 3; k++) push(0, 64'h20 + 64'(k));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("under_idle", 64'({cons[0], vld[0]}), 64'd0);
            cyc();
        end
        enq(0, 64'h20, 1'b0, 1'b1);
        enq(0, 64'h21, 1'b0, 1'b1);
        enq(0, 64'h22, 1'b1, 1'b1);
        drn[0] = 1'b1;
        wait_drain(0, 100);
        chk("drain_wcnt", 64'(wcnt[0]), 64'd3);
        chk("drain_bcnt", 64'(bcnt[0]), 64'd1);
        drn[0] = 1'b0;

        // Backpressure with 7 words queued
        do_reset();
        rdy[0] = 1'b0;
        p0 = pops[0];
        for (int k = 0; k < 7; k++) push(0, 64'(k));
        repeat (10) cyc();
        chk("bp_pops", 64'(pops[0] - p0), 64'd2);
        chk("bp_util", 64'(fcnt[0]), 64'd5);
        chk("bp_valid", 64'(vld[0]), 64'd1);
        chk("bp_data", dat[0], 64'd0);
        for (int k = 0; k < 7; k++) enq(0, 64'(k), (k == 3) || (k == 6), 1'b1);
        drn[0] = 1'b1;
        rdy[0] = 1'b1;
        wait_drain(0, 100);
        chk("bp_wcnt", 64'(wcnt[0]), 64'd7);
        chk("bp_bcnt", 64'(bcnt[0]), 64'd2);

        // Random out_ready over 1000 words with drain enabled
        do_reset();
        drn[0] = 1'b1;
        l0 = lasts[0];
        pdone = 1'b0;
        for (int k = 0; k < 1000; k++) enq(0, 64'h1000 + 64'(k), 1'b0, 1'b0);
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 2)) cyc();
                    push(0, 64'h1000 + 64'(k));
                end
                pdone = 1'b1;
            end
            begin
                int n = 0;
                while (!(pdone && erd[0] == ewr[0] && !busy_s[0]) && n < 30000) begin
                    rdy[0] = 1'($urandom_range(0, 1));
                    cyc();
                    n++;
                end
                chk("rand_timeout", 64'(n >= 30000), 64'd0);
            end
        join
        chk("rand_wcnt", 64'(wcnt[0]), 64'd1000);
        chk("rand_bcnt", 64'(bcnt[0]), 64'(16'(lasts[0] - l0)));
        chk("rand_final_last", 64'(last_seen[0]), 64'd1);
        drn[0] = 1'b0;

        // Asynchronous reset mid-burst with occupancy 2, remaining 2
        do_reset();
        rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) enq(0, 64'h30 + 64'(k), k == 3, 1'b1);
        for (int k = 0; k < 4; k++) push(0, 64'h30 + 64'(k));
        wait_drain(0, 50);
        rdy[0] = 1'b0;
        p0 = pops[0];
        for (int k = 0; k < 4; k++) push(0, 64'h40 + 64'(k));
        begin
            int n = 0;
            while (pops[0] - p0 < 2 && n < 50) begin
                cyc();
                n++;
            end
            chk("pre_rst_timeout", 64'(n >= 50), 64'd0);
        end
        chk("pre_rst_wcnt", 64'(wcnt[0]), 64'd4);
        chk("pre_rst_valid", 64'(vld[0]), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 64'(vld[0]), 64'd0);
        chk("async_consume", 64'(cons[0]), 64'd0);
        chk("async_busy", 64'(busy_s[0]), 64'd0);
        chk("async_wcnt", 64'(wcnt[0]), 64'd0);
        chk("async_bcnt", 64'(bcnt[0]), 64'd0);
        chk("async_data", dat[0], 64'd0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) enq(0, 64'h50 + 64'(k), k == 3, 1'b1);
        for (int k = 0; k < 4; k++) push(0, 64'h50 + 64'(k));
        wait_drain(0, 50);
        chk("post_rst_wcnt", 64'(wcnt[0]), 64'd4);
        chk("post_rst_bcnt", 64'(bcnt[0]), 64'd1);

        // BURST_LEN = 7 with a full FIFO, producer keeps writing during the burst
        do_reset();
        mon_en[1] = 1'b1;
        rdy[1] = 1'b1;
        for (int k = 0; k < 14; k++) enq(1, 64'h70 + 64'(k), (k == 6) || (k == 13), 1'b1);
        for (int k = 0; k < 14; k++) push(1, 64'h70 + 64'(k));
        wait_drain(1, 200);
        chk("bl7_wcnt", 64'(wcnt[1]), 64'd14);
        chk("bl7_bcnt", 64'(bcnt[1]), 64'd2);
        chk("bl7_pop_run", 64'(maxrun[1]), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
